ctrl_sequencer: RTL and testbench

Registered, parametrised control unit that succeeds the purely combinational decoder in the processor. It decodes the same 5-bit opcode / ALU-function fields into datapath controls one cycle after acceptance, and adds sequential behaviour: a stall handshake, a multi-cycle multiply/divide wait with timeout, and a dedicated status-register (r30) writeback cycle on overflow or mul/div exception. It sits between fetch/decode and the execute stage of the processor.

---
 rtl/ctrl_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 tb/tb_ctrl_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequencer
// Purpose  : Registered instruction-control unit. Decodes the opcode and
//            ALU-function fields into datapath controls one cycle after
//            acceptance. Adds a stall handshake, an r30 status-writeback
//            cycle on ALU overflow, and (optionally) a multi-cycle mul/div
//            wait with timeout.
// Revision : 1.0 - initial release
// Config   : CTRL_MULDIV_EN - when defined, mul/div support (MDWAIT state,
//            timeout counter, start pulses) is compiled in. When undefined,
//            functions 00110/00111 decode as NOP.
// Ports    : clk_i              rising-edge clock
//            rst_ni             asynchronous active-low reset
//            insn_valid_i       instruction fields valid (ignored when stalled)
//            opcode_i/alu_in_i  opcode / R-type function field
//            ovf_i              ALU overflow, watched after add/addi/sub
//            md_ready_i         mul/div result ready
//            md_exception_i     mul/div exception (qualified by md_ready_i)
//            stall_o            upstream must hold its instruction
//            ctrl_valid_o       controls valid this cycle
//            DMwe_o..ALUinB_o   single-bit datapath controls
//            Rt_o               register-select mode (00 R,01 I,10 JI,11 JII)
//            ALUop_o            ALU opcode
//            md_start_*_o       one-cycle mul/div start pulses
//            status_we_o        write rstatus_o into r30
//            rstatus_o          exception code (1 add,2 addi,3 sub,4 mul,5 div)
// ============================================================================
module ctrl_sequencer #(
  parameter int OPW        = 5,
  parameter int STATUS_W   = 32,
  parameter int MD_TIMEOUT = 40
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                insn_valid_i,
  input  logic [OPW-1:0]      opcode_i,
  input  logic [OPW-1:0]      alu_in_i,
  input  logic                ovf_i,
  input  logic                md_ready_i,
  input  logic                md_exception_i,
  output logic                stall_o,
  output logic                ctrl_valid_o,
  output logic                DMwe_o,
  output logic                Rwe_o,
  output logic                Rwd_o,
  output logic                Branch_o,
  output logic                Jump_o,
  output logic                jal_o,
  output logic                jr_o,
  output logic                ALUinB_o,
  output logic [1:0]          Rt_o,
  output logic [OPW-1:0]      ALUop_o,
  output logic                md_start_mult_o,
  output logic                md_start_div_o,
  output logic                status_we_o,
  output logic [STATUS_W-1:0] rstatus_o
);

  localparam logic [OPW-1:0] c_OP_RTYPE = OPW'(5'b00000);
  localparam logic [OPW-1:0] c_OP_J     = OPW'(5'b00001);
  localparam logic [OPW-1:0] c_OP_BNE   = OPW'(5'b00010);
  localparam logic [OPW-1:0] c_OP_JAL   = OPW'(5'b00011);
  localparam logic [OPW-1:0] c_OP_JR    = OPW'(5'b00100);
  localparam logic [OPW-1:0] c_OP_ADDI  = OPW'(5'b00101);
  localparam logic [OPW-1:0] c_OP_BLT   = OPW'(5'b00110);
  localparam logic [OPW-1:0] c_OP_SW    = OPW'(5'b00111);
  localparam logic [OPW-1:0] c_OP_LW    = OPW'(5'b01000);
  localparam logic [OPW-1:0] c_OP_SETX  = OPW'(5'b10101);
  localparam logic [OPW-1:0] c_OP_BEX   = OPW'(5'b10110);

  localparam logic [OPW-1:0] c_FN_ADD = OPW'(5'b00000);
  localparam logic [OPW-1:0] c_FN_SUB = OPW'(5'b00001);
  localparam logic [OPW-1:0] c_FN_AND = OPW'(5'b00010);
  localparam logic [OPW-1:0] c_FN_OR  = OPW'(5'b00011);
  localparam logic [OPW-1:0] c_FN_SLL = OPW'(5'b00100);
  localparam logic [OPW-1:0] c_FN_SRA = OPW'(5'b00101);
`ifdef CTRL_MULDIV_EN
  localparam logic [OPW-1:0] c_FN_MUL = OPW'(5'b00110);
  localparam logic [OPW-1:0] c_FN_DIV = OPW'(5'b00111);
  localparam int             c_CNT_W  = $clog2(MD_TIMEOUT);
`endif

  localparam logic [2:0] c_EXC_ADD  = 3'd1;
  localparam logic [2:0] c_EXC_ADDI = 3'd2;
  localparam logic [2:0] c_EXC_SUB  = 3'd3;
  localparam logic [2:0] c_EXC_MUL  = 3'd4;
  localparam logic [2:0] c_EXC_DIV  = 3'd5;

`ifdef CTRL_MULDIV_EN
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_EXC = 2'd1, ST_MDWAIT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_EXC = 2'd1} state_e;
`endif

  typedef struct packed {
    logic           dmwe;
    logic           rwe;
    logic           rwd;
    logic           branch;
    logic           jump;
    logic           jal;
    logic           jr;
    logic           aluinb;
    logic [1:0]     rt;
    logic [OPW-1:0] aluop;
  } ctrl_t;

  state_e              state_q;
  ctrl_t               ctrl_q;
  logic                ctrl_valid_q;
  logic                status_we_q;
  logic [STATUS_W-1:0] rstatus_q;
  // Set for exactly the cycle following an add/addi/sub issue; ovf_code_q
  // remembers which of the three it was.
  logic                ovf_chk_q;
  logic [2:0]          ovf_code_q;

  ctrl_t               dec_d;
  logic [2:0]          dec_code_d;
  logic                dec_mul_d;
  logic                dec_div_d;
  logic                accept;

`ifdef CTRL_MULDIV_EN
  logic                start_mult_q;
  logic                start_div_q;
  logic                md_div_q;
  logic [c_CNT_W-1:0]  cnt_q;
`else
  logic                unused_md_inputs;
  assign unused_md_inputs = md_ready_i ^ md_exception_i;
`endif

  // Overflow stalls in the detection cycle itself so the instruction offered
  // alongside the faulting result is held rather than lost.
  assign stall_o = (state_q != ST_RUN) || (ovf_chk_q && ovf_i);
  assign accept  = insn_valid_i && !stall_o;

  always_comb begin
    dec_d      = '0;
    dec_code_d = 3'd0;
    dec_mul_d  = 1'b0;
    dec_div_d  = 1'b0;
    case (opcode_i)
      c_OP_RTYPE: begin
        case (alu_in_i)
          c_FN_ADD, c_FN_SUB, c_FN_AND, c_FN_OR, c_FN_SLL, c_FN_SRA: begin
            dec_d.rwe   = 1'b1;
            dec_d.aluop = alu_in_i;
          end
`ifdef CTRL_MULDIV_EN
          c_FN_MUL: begin
            dec_d.aluop = alu_in_i;
            dec_mul_d   = 1'b1;
          end
          c_FN_DIV: begin
            dec_d.aluop = alu_in_i;
            dec_div_d   = 1'b1;
          end
`endif
          default: ;
        endcase
        if (alu_in_i == c_FN_ADD)      dec_code_d = c_EXC_ADD;
        else if (alu_in_i == c_FN_SUB) dec_code_d = c_EXC_SUB;
      end
      c_OP_ADDI: begin
        dec_d.rt     = 2'b01;
        dec_d.rwe    = 1'b1;
        dec_d.aluinb = 1'b1;
        dec_code_d   = c_EXC_ADDI;
      end
      c_OP_SW: begin
        dec_d.dmwe   = 1'b1;
        dec_d.aluinb = 1'b1;
      end
      c_OP_LW: begin
        dec_d.rwe    = 1'b1;
        dec_d.rwd    = 1'b1;
        dec_d.aluinb = 1'b1;
      end
      c_OP_J: begin
        dec_d.rt   = 2'b10;
        dec_d.jump = 1'b1;
      end
      c_OP_JAL: begin
        dec_d.rt   = 2'b10;
        dec_d.jump = 1'b1;
        dec_d.jal  = 1'b1;
        dec_d.rwe  = 1'b1;
      end
      c_OP_JR: begin
        dec_d.rt   = 2'b11;
        dec_d.jump = 1'b1;
        dec_d.jr   = 1'b1;
      end
      c_OP_BNE, c_OP_BLT: begin
        dec_d.rt     = 2'b01;
        dec_d.branch = 1'b1;
      end
      c_OP_BEX: begin
        dec_d.rt     = 2'b10;
        dec_d.branch = 1'b1;
      end
      c_OP_SETX: begin
        dec_d.rt     = 2'b10;
        dec_d.rwe    = 1'b1;
        dec_d.aluinb = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_RUN;
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      status_we_q  <= 1'b0;
      rstatus_q    <= '0;
      ovf_chk_q    <= 1'b0;
      ovf_code_q   <= 3'd0;
`ifdef CTRL_MULDIV_EN
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
      md_div_q     <= 1'b0;
      cnt_q        <= '0;
`endif
    end else begin
      // Every output is a one-cycle event unless re-asserted below.
      ctrl_q       <= '0;
      ctrl_valid_q <= 1'b0;
      status_we_q  <= 1'b0;
      rstatus_q    <= '0;
      ovf_chk_q    <= 1'b0;
`ifdef CTRL_MULDIV_EN
      start_mult_q <= 1'b0;
      start_div_q  <= 1'b0;
`endif
      case (state_q)
        ST_RUN: begin
          if (ovf_chk_q && ovf_i) begin
            state_q      <= ST_EXC;
            ctrl_valid_q <= 1'b1;
            status_we_q  <= 1'b1;
            rstatus_q    <= STATUS_W'(ovf_code_q);
          end else if (accept) begin
            ctrl_q       <= dec_d;
            ctrl_valid_q <= 1'b1;
            ovf_chk_q    <= (dec_code_d != 3'd0);
            ovf_code_q   <= dec_code_d;
`ifdef CTRL_MULDIV_EN
            if (dec_mul_d || dec_div_d) begin
              state_q      <= ST_MDWAIT;
              cnt_q        <= '0;
              md_div_q     <= dec_div_d;
              start_mult_q <= dec_mul_d;
              start_div_q  <= dec_div_d;
            end
`endif
          end
        end
        ST_EXC: state_q <= ST_RUN;
`ifdef CTRL_MULDIV_EN
        ST_MDWAIT: begin
          // md_ready_i is checked before the timeout so a result arriving on
          // the last allowed cycle still completes normally.
          if (md_ready_i && !md_exception_i) begin
            state_q      <= ST_RUN;
            ctrl_valid_q <= 1'b1;
            ctrl_q.rwe   <= 1'b1;
            ctrl_q.aluop <= md_div_q ? c_FN_DIV : c_FN_MUL;
          end else if (md_ready_i || (cnt_q == c_CNT_W'(MD_TIMEOUT - 1))) begin
            state_q      <= ST_EXC;
            ctrl_valid_q <= 1'b1;
            status_we_q  <= 1'b1;
            rstatus_q    <= STATUS_W'(md_div_q ? c_EXC_DIV : c_EXC_MUL);
          end else begin
            cnt_q <= cnt_q + c_CNT_W'(1);
          end
        end
`endif
        default: state_q <= ST_RUN;
      endcase
    end
  end

  assign ctrl_valid_o = ctrl_valid_q;
  assign DMwe_o       = ctrl_q.dmwe;
  assign Rwe_o        = ctrl_q.rwe;
  assign Rwd_o        = ctrl_q.rwd;
  assign Branch_o     = ctrl_q.branch;
  assign Jump_o       = ctrl_q.jump;
  assign jal_o        = ctrl_q.jal;
  assign jr_o         = ctrl_q.jr;
  assign ALUinB_o     = ctrl_q.aluinb;
  assign Rt_o         = ctrl_q.rt;
  assign ALUop_o      = ctrl_q.aluop;
  assign status_we_o  = status_we_q;
  assign rstatus_o    = rstatus_q;
`ifdef CTRL_MULDIV_EN
  assign md_start_mult_o = start_mult_q;
  assign md_start_div_o  = start_div_q;
`else
  assign md_start_mult_o = 1'b0;
  assign md_start_div_o  = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequencer
// Purpose  : Self-checking bench for ctrl_sequencer. Directed scenarios plus
//            randomized traffic, compared every cycle against a behavioural
//            model of the instruction set and sequencing rules. Follows the
//            CTRL_MULDIV_EN setting of the build.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_sequencer;

  localparam int TO = 40;
`ifdef CTRL_MULDIV_EN
  localparam bit MD_EN = 1'b1;
`else
  localparam bit MD_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        insn_valid = 1'b0;
  logic [4:0]  opcode = '0;
  logic [4:0]  alu_in = '0;
  logic        ovf = 1'b0;
  logic        md_ready = 1'b0;
  logic        md_exception = 1'b0;
  logic        stall, ctrl_valid, DMwe, Rwe, Rwd, Branch, Jump, jal, jr, ALUinB;
  logic [1:0]  Rt;
  logic [4:0]  ALUop;
  logic        md_start_mult, md_start_div, status_we;
  logic [31:0] rstatus;

  ctrl_sequencer #(.OPW(5), .STATUS_W(32), .MD_TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_ni(rst_n), .insn_valid_i(insn_valid), .opcode_i(opcode),
    .alu_in_i(alu_in), .ovf_i(ovf), .md_ready_i(md_ready),
    .md_exception_i(md_exception), .stall_o(stall), .ctrl_valid_o(ctrl_valid),
    .DMwe_o(DMwe), .Rwe_o(Rwe), .Rwd_o(Rwd), .Branch_o(Branch), .Jump_o(Jump),
    .jal_o(jal), .jr_o(jr), .ALUinB_o(ALUinB), .Rt_o(Rt), .ALUop_o(ALUop),
    .md_start_mult_o(md_start_mult), .md_start_div_o(md_start_div),
    .status_we_o(status_we), .rstatus_o(rstatus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Output vector: {ctrl_valid, DMwe, Rwe, Rwd, Branch, Jump, jal, jr, ALUinB,
  //                 Rt, ALUop, start_mult, start_div, status_we, rstatus}
  logic [50:0] m_out;
  int          m_watch;   // overflow code being watched this cycle, 0 = none
  int          m_wait;    // cycles spent waiting on mul/div, -1 = not waiting
  int          m_md_code; // 4 mul, 5 div
  bit          m_in_exc;

  function automatic logic [50:0] pk(bit cv, bit dm, bit we, bit wd, bit br,
                                     bit jp, bit jl, bit jrr, bit inb,
                                     logic [1:0] rt, logic [4:0] aop,
                                     bit sm, bit sd, bit swe, int rs);
    return {cv, dm, we, wd, br, jp, jl, jrr, inb, rt, aop, sm, sd, swe, 32'(rs)};
  endfunction

  function automatic int ovf_code(logic [4:0] op, logic [4:0] fn);
    if (op == 5'd0 && fn == 5'd0) return 1;
    if (op == 5'd5)               return 2;
    if (op == 5'd0 && fn == 5'd1) return 3;
    return 0;
  endfunction

  function automatic int md_kind(logic [4:0] op, logic [4:0] fn);
    if (!MD_EN || op != 5'd0) return 0;
    if (fn == 5'd6) return 4;
    if (fn == 5'd7) return 5;
    return 0;
  endfunction

  function automatic logic [50:0] decode(logic [4:0] op, logic [4:0] fn);
    logic [50:0] nop;
    nop = pk(1,0,0,0,0,0,0,0,0, 2'b00, 5'd0, 0,0,0, 0);
    case (op)
      5'd0: begin
        if (fn <= 5'd5)         return pk(1,0,1,0,0,0,0,0,0, 2'b00, fn, 0,0,0, 0);
        if (md_kind(op, fn) != 0)
          return pk(1,0,0,0,0,0,0,0,0, 2'b00, fn, fn == 5'd6, fn == 5'd7, 0, 0);
        return nop;
      end
      5'd5:  return pk(1,0,1,0,0,0,0,0,1, 2'b01, 5'd0, 0,0,0, 0); // addi
      5'd7:  return pk(1,1,0,0,0,0,0,0,1, 2'b00, 5'd0, 0,0,0, 0); // sw
      5'd8:  return pk(1,0,1,1,0,0,0,0,1, 2'b00, 5'd0, 0,0,0, 0); // lw
      5'd1:  return pk(1,0,0,0,0,1,0,0,0, 2'b10, 5'd0, 0,0,0, 0); // j
      5'd3:  return pk(1,0,1,0,0,1,1,0,0, 2'b10, 5'd0, 0,0,0, 0); // jal
      5'd4:  return pk(1,0,0,0,0,1,0,1,0, 2'b11, 5'd0, 0,0,0, 0); // jr
      5'd2,
      5'd6:  return pk(1,0,0,0,1,0,0,0,0, 2'b01, 5'd0, 0,0,0, 0); // bne, blt
      5'd22: return pk(1,0,0,0,1,0,0,0,0, 2'b10, 5'd0, 0,0,0, 0); // bex
      5'd21: return pk(1,0,1,0,0,0,0,0,1, 2'b10, 5'd0, 0,0,0, 0); // setx
      default: return nop;
    endcase
  endfunction

  function automatic logic [50:0] exc_out(int code);
    return pk(1,0,0,0,0,0,0,0,0, 2'b00, 5'd0, 0,0,1, code);
  endfunction

  task automatic model_reset();
    m_out = '0; m_watch = 0; m_wait = -1; m_md_code = 0; m_in_exc = 0;
  endtask

  // Advance the model by one rising edge using the inputs held across it.
  task automatic model_edge();
    if (m_in_exc) begin
      m_in_exc = 0; m_out = '0; m_watch = 0;
    end else if (m_wait >= 0) begin
      m_watch = 0;
      if (md_ready && !md_exception) begin
        m_out  = pk(1,0,1,0,0,0,0,0,0, 2'b00, (m_md_code == 4) ? 5'd6 : 5'd7, 0,0,0, 0);
        m_wait = -1;
      end else if (md_ready || m_wait == TO - 1) begin
        m_out = exc_out(m_md_code); m_in_exc = 1; m_wait = -1;
      end else begin
        m_out = '0; m_wait++;
      end
    end else if (m_watch != 0 && ovf) begin
      m_out = exc_out(m_watch); m_in_exc = 1; m_watch = 0;
    end else if (insn_valid) begin
      m_out   = decode(opcode, alu_in);
      m_watch = ovf_code(opcode, alu_in);
      if (md_kind(opcode, alu_in) != 0) begin
        m_wait = 0; m_md_code = md_kind(opcode, alu_in);
      end
    end else begin
      m_out = '0; m_watch = 0;
    end
  endtask

  task automatic check(string tag);
    logic        exp_stall;
    logic [50:0] obs;
    exp_stall = m_in_exc || (m_wait >= 0) || (m_watch != 0 && ovf);
    obs = {ctrl_valid, DMwe, Rwe, Rwd, Branch, Jump, jal, jr, ALUinB, Rt, ALUop,
           md_start_mult, md_start_div, status_we, rstatus};
    checks++;
    assert (stall === exp_stall) else begin
      errors++;
      $error("FAIL %s stall observed %b expected %b", tag, stall, exp_stall);
    end
    checks++;
    assert (obs === m_out) else begin
      errors++;
      $error("FAIL %s outputs observed %h expected %h", tag, obs, m_out);
    end
  endtask

  // One clock cycle: drive inputs after the falling edge, check, then clock.
  task automatic cyc(string tag, logic v, logic [4:0] op, logic [4:0] fn,
                     logic ov, logic rdy, logic mex);
    insn_valid = v; opcode = op; alu_in = fn; ovf = ov;
    md_ready = rdy; md_exception = mex;
    #1 check(tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset(string tag, logic rdy);
    md_ready = rdy;
    rst_n = 1'b0;
    model_reset();
    #1 check(tag);
    @(posedge clk);
    #1 check(tag);
    @(negedge clk);
    rst_n = 1'b1;
    md_ready = 1'b0;
  endtask

  initial begin
    logic [4:0] ops [12];
    ops = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd21, 5'd22, 5'd31};
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    do_reset("reset", 1'b0);

    // add r1,r2,r3 then observe its controls
    cyc("add_issue", 1, 5'd0, 5'd0, 0, 0, 0);
    cyc("add_out",   0, 5'd0, 5'd0, 0, 0, 0);
    cyc("idle",      0, 5'd0, 5'd0, 0, 0, 0);

    // sub with overflow; an addi is held behind it
    cyc("sub_issue", 1, 5'd0, 5'd1, 0, 0, 0);
    cyc("sub_ovf",   1, 5'd5, 5'd0, 1, 0, 0);
    cyc("sub_exc",   1, 5'd5, 5'd0, 0, 0, 0);
    cyc("held_acc",  1, 5'd5, 5'd0, 0, 0, 0);
    cyc("addi_out",  0, 5'd0, 5'd0, 1, 0, 0);
    cyc("addi_exc",  0, 5'd0, 5'd0, 0, 0, 0);
    cyc("post_exc",  0, 5'd0, 5'd0, 0, 0, 0);

    // overflow ignored after non-arithmetic instruction
    cyc("and_issue", 1, 5'd0, 5'd2, 0, 0, 0);
    cyc("and_noovf", 0, 5'd0, 5'd0, 1, 0, 0);

    // mul, result ready in the 8th wait cycle
    cyc("mul_issue", 1, 5'd0, 5'd6, 0, 0, 0);
    for (int i = 0; i < 7; i++) cyc("mul_wait", 1, 5'd8, 5'd0, 0, 0, 0);
    cyc("mul_ready", 1, 5'd8, 5'd0, 0, 1, 0);
    cyc("mul_wb",    0, 5'd0, 5'd0, 0, 0, 0);
    cyc("mul_done",  0, 5'd0, 5'd0, 0, 0, 0);

    // div that never completes -> timeout exception code 5
    cyc("div_issue", 1, 5'd0, 5'd7, 0, 0, 0);
    for (int i = 0; i < TO + 3; i++) cyc("div_timeout", 0, 5'd0, 5'd0, 0, 0, 0);

    // mul with exception
    cyc("mulx_issue", 1, 5'd0, 5'd6, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("mulx_wait", 0, 5'd0, 5'd0, 0, 0, 0);
    cyc("mulx_ready", 0, 5'd0, 5'd0, 0, 1, 1);
    cyc("mulx_exc",   0, 5'd0, 5'd0, 0, 0, 0);
    cyc("mulx_done",  0, 5'd0, 5'd0, 0, 0, 0);

    // reset in the middle of a mul wait, md_ready high at the same edge
    cyc("mulr_issue", 1, 5'd0, 5'd6, 0, 0, 0);
    for (int i = 0; i < 3; i++) cyc("mulr_wait", 0, 5'd0, 5'd0, 0, 0, 0);
    do_reset("reset_mdwait", 1'b1);
    cyc("after_rst", 0, 5'd0, 5'd0, 0, 1, 0);
    cyc("after_rst2", 0, 5'd0, 5'd0, 0, 0, 0);

    // unknown opcode and unknown function
    cyc("op31",    1, 5'd31, 5'd0, 0, 0, 0);
    cyc("fn_bad",  1, 5'd0, 5'd12, 0, 0, 0);
    cyc("fn_bad_out", 0, 5'd0, 5'd0, 0, 0, 0);

    // every opcode back to back
    foreach (ops[i]) cyc("walk", 1, ops[i], 5'(i % 6), 0, 0, 0);
    cyc("walk_end", 0, 5'd0, 5'd0, 0, 0, 0);

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] rop;
      rop = ($urandom_range(0, 5) == 0) ? 5'($urandom) : ops[$urandom_range(0, 11)];
      if ($urandom_range(0, 499) == 0) do_reset("rand_reset", 1'($urandom));
      else cyc("random", 1'($urandom_range(0, 3) != 0), rop, 5'($urandom_range(0, 9)),
               1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 7) == 0),
               1'($urandom_range(0, 2) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
